// File: rtl/delayed_branch_resolver_if.sv
// Delayed-branch resolver bus: packet inputs from BGU, flags from the
// resolve stage, and replay/flush outputs back to BGU and the pipeline.
interface delayed_branch_resolver_if;
   logic        fetch_next_in;
   logic [15:0] p0_delayed_B_1in;
   logic [2:0]  p0_delayed_cond_1in;
   logic [15:0] p1_delayed_B_1in;
   logic [2:0]  p1_delayed_cond_1in;
   logic        N;
   logic        V;
   logic        Z;
   logic        p0_do_delayed_B;
   logic        p1_do_delayed_B;
   logic [15:0] replay_IR;
   logic        flush_out;
   logic        busy;

   modport master (
      output fetch_next_in, p0_delayed_B_1in, p0_delayed_cond_1in,
             p1_delayed_B_1in, p1_delayed_cond_1in, N, V, Z,
      input  p0_do_delayed_B, p1_do_delayed_B, replay_IR, flush_out, busy
   );

   modport slave (
      input  fetch_next_in, p0_delayed_B_1in, p0_delayed_cond_1in,
             p1_delayed_B_1in, p1_delayed_cond_1in, N, V, Z,
      output p0_do_delayed_B, p1_do_delayed_B, replay_IR, flush_out, busy
   );
endinterface

// File: rtl/delayed_branch_resolver.sv
// Delayed-branch resolver: carries per-lane branch packets down the pipe,
// evaluates cond against N/V/Z at the resolve stage, requests a replay of
// the oldest hit, flushes younger work and blanks capture while refilling.
module delayed_branch_resolver #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   delayed_branch_resolver_if.slave bus
);
   // Stage 1 is the packet on the input; stages 2..DEPTH are registers.
   localparam int unsigned NREG = (DEPTH > 1) ? DEPTH - 1 : 1;

   typedef enum logic [1:0] {IDLE, REPLAY, DRAIN} state_t;

   state_t      state, state_nxt;
   logic [2:0]  drain_cnt, drain_cnt_nxt;
   logic        win_lane;
   logic [15:0] replay_ir_q;

   logic        vld_q    [2][NREG];
   logic [15:0] ir_q     [2][NREG];
   logic [2:0]  cond_q   [2][NREG];

   logic        stg_vld  [2][DEPTH];
   logic [15:0] stg_ir   [2][DEPTH];
   logic [2:0]  stg_cond [2][DEPTH];

   logic resolve_en;
   logic p0_take;
   logic p1_take;
   logic hit;

   function automatic logic cond_true(input logic [2:0] c, input logic n,
                                      input logic v, input logic z);
      logic lt;
      lt = n ^ v;
      case (c)
         3'd0:    cond_true = 1'b0;
         3'd1:    cond_true = 1'b1;
         3'd2:    cond_true = z;
         3'd3:    cond_true = ~z;
         3'd4:    cond_true = lt;
         3'd5:    cond_true = lt | z;
         3'd6:    cond_true = ~(lt | z);
         default: cond_true = ~lt;
      endcase
   endfunction

   // Unified stage view: incoming packet at stage 1, registers behind it
   always_comb begin
      stg_ir[0][0]   = bus.p0_delayed_B_1in;
      stg_cond[0][0] = bus.p0_delayed_cond_1in;
      stg_vld[0][0]  = (state == IDLE) && (bus.p0_delayed_cond_1in != 3'd0);
      stg_ir[1][0]   = bus.p1_delayed_B_1in;
      stg_cond[1][0] = bus.p1_delayed_cond_1in;
      stg_vld[1][0]  = (state == IDLE) && (bus.p1_delayed_cond_1in != 3'd0);
      for (int unsigned l = 0; l < 2; l++) begin
         for (int unsigned k = 1; k < DEPTH; k++) begin
            stg_ir[l][k]   = ir_q[l][k-1];
            stg_cond[l][k] = cond_q[l][k-1];
            stg_vld[l][k]  = vld_q[l][k-1];
         end
      end
   end

   // Resolve at stage DEPTH; lane 0 is older and takes priority
   always_comb begin
      resolve_en = bus.fetch_next_in && (state == IDLE) && !rst;
      p0_take    = resolve_en && stg_vld[0][DEPTH-1] &&
                   cond_true(stg_cond[0][DEPTH-1], bus.N, bus.V, bus.Z);
      p1_take    = resolve_en && !p0_take && stg_vld[1][DEPTH-1] &&
                   cond_true(stg_cond[1][DEPTH-1], bus.N, bus.V, bus.Z);
      hit        = p0_take || p1_take;
   end

   // Stage registers: shift on advance, a hit flushes everything younger
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned l = 0; l < 2; l++) begin
            for (int unsigned k = 0; k < NREG; k++) begin
               vld_q[l][k] <= 1'b0;
            end
         end
      end else if (bus.fetch_next_in) begin
         for (int unsigned l = 0; l < 2; l++) begin
            for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
               vld_q[l][k]  <= stg_vld[l][k] && !hit;
               ir_q[l][k]   <= stg_ir[l][k];
               cond_q[l][k] <= stg_cond[l][k];
            end
         end
      end
   end

   // Next-state logic for the replay/drain sequencer
   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      unique case (state)
         IDLE: begin
            if (hit) state_nxt = REPLAY;
         end
         REPLAY: begin
            if (bus.fetch_next_in) begin
               if (DRAIN_CYCLES == 0) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt     = DRAIN;
                  drain_cnt_nxt = 3'(DRAIN_CYCLES);
               end
            end
         end
         DRAIN: begin
            if (bus.fetch_next_in) begin
               if (drain_cnt == 3'd1) state_nxt = IDLE;
               drain_cnt_nxt = drain_cnt - 3'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Sequencer state, winning lane and latched replay IR
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         drain_cnt   <= '0;
         win_lane    <= 1'b0;
         replay_ir_q <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         if (hit) begin
            win_lane    <= p1_take;
            replay_ir_q <= p0_take ? stg_ir[0][DEPTH-1] : stg_ir[1][DEPTH-1];
         end
      end
   end

   // Output drive
   always_comb begin
      bus.p0_do_delayed_B = (state == REPLAY) && !win_lane;
      bus.p1_do_delayed_B = (state == REPLAY) && win_lane;
      bus.replay_IR       = replay_ir_q;
      bus.flush_out       = hit;
      bus.busy            = (state != IDLE);
   end
endmodule

// File: tb/tb_delayed_branch_resolver.sv
// Bench for delayed_branch_resolver: directed scenarios with literal
// expectations, then randomized traffic checked against a packet-level model.
module tb_delayed_branch_resolver;
   localparam int DEPTH        = 2;
   localparam int DRAIN_CYCLES = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   check_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   delayed_branch_resolver_if bus();

   delayed_branch_resolver #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      bit          v0, v1;
      logic [15:0] ir0, ir1;
      logic [2:0]  c0, c1;
   } pair_t;

   pair_t       m_pipe[$];   // registered pairs, [0] = youngest
   bit          m_replay;
   bit          m_lane;
   logic [15:0] m_ir;
   int          m_drain;     // advances of blanking still owed

   function automatic bit cond_holds(input logic [2:0] c, input logic n,
                                     input logic v, input logic z);
      bit less = (n != v);
      case (int'(c))
         0: return 1'b0;
         1: return 1'b1;
         2: return z;
         3: return !z;
         4: return less;
         5: return less || z;
         6: return !(less || z);
         default: return !less;
      endcase
   endfunction

   function automatic bit m_busy();
      return m_replay || (m_drain > 0);
   endfunction

   function automatic pair_t input_pair();
      pair_t p;
      p.ir0 = bus.p0_delayed_B_1in;   p.c0 = bus.p0_delayed_cond_1in;
      p.ir1 = bus.p1_delayed_B_1in;   p.c1 = bus.p1_delayed_cond_1in;
      p.v0  = !m_busy() && (p.c0 != 3'd0);
      p.v1  = !m_busy() && (p.c1 != 3'd0);
      return p;
   endfunction

   function automatic void m_reset();
      pair_t e;
      e.v0 = 0; e.v1 = 0; e.ir0 = '0; e.ir1 = '0; e.c0 = '0; e.c1 = '0;
      m_pipe.delete();
      for (int i = 0; i < DEPTH - 1; i++) m_pipe.push_back(e);
      m_replay = 0; m_lane = 0; m_ir = '0; m_drain = 0;
   endfunction

   function automatic void m_resolve(output bit hit, output bit lane, output logic [15:0] ir);
      pair_t p;
      hit = 0; lane = 0; ir = '0;
      if (rst || !bus.fetch_next_in || m_busy()) return;
      p = (DEPTH == 1) ? input_pair() : m_pipe[DEPTH-2];
      if (p.v0 && cond_holds(p.c0, bus.N, bus.V, bus.Z)) begin
         hit = 1; lane = 0; ir = p.ir0;
      end else if (p.v1 && cond_holds(p.c1, bus.N, bus.V, bus.Z)) begin
         hit = 1; lane = 1; ir = p.ir1;
      end
   endfunction

   always @(posedge clk) begin
      bit h, l;
      logic [15:0] ir;
      pair_t np;
      if (rst) begin
         m_reset();
      end else if (bus.fetch_next_in) begin
         m_resolve(h, l, ir);
         np = input_pair();
         if (h) begin
            np.v0 = 0; np.v1 = 0;
            foreach (m_pipe[i]) begin m_pipe[i].v0 = 0; m_pipe[i].v1 = 0; end
            m_replay = 1; m_lane = l; m_ir = ir;
         end else if (m_replay) begin
            m_replay = 0; m_drain = DRAIN_CYCLES;
         end else if (m_drain > 0) begin
            m_drain--;
         end
         if (DEPTH > 1) begin
            void'(m_pipe.pop_back());
            m_pipe.push_front(np);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT against the model every cycle, mid-cycle
   always @(negedge clk) begin
      bit h, l;
      logic [15:0] ir;
      if (check_en) begin
         m_resolve(h, l, ir);
         chk("busy", bus.busy, m_busy());
         chk("p0_do", bus.p0_do_delayed_B, m_replay && !m_lane);
         chk("p1_do", bus.p1_do_delayed_B, m_replay && m_lane);
         chk("flush", bus.flush_out, h);
         if (m_replay) chk("replay_IR", bus.replay_IR, m_ir);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic f, input logic [2:0] c0, input logic [15:0] i0,
                        input logic [2:0] c1, input logic [15:0] i1,
                        input logic n, input logic v, input logic z);
      bus.fetch_next_in       = f;
      bus.p0_delayed_cond_1in = c0;  bus.p0_delayed_B_1in = i0;
      bus.p1_delayed_cond_1in = c1;  bus.p1_delayed_B_1in = i1;
      bus.N = n; bus.V = v; bus.Z = z;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      m_reset();
      drive(0, 0, 16'h0, 0, 16'h0, 0, 0, 0);
      repeat (2) tick();
      @(negedge clk);
      chk("rst_p0_do", bus.p0_do_delayed_B, 0);
      chk("rst_p1_do", bus.p1_do_delayed_B, 0);
      chk("rst_flush", bus.flush_out, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_replay_IR", bus.replay_IR, 16'h0000);
      check_en = 1;
      tick();
      rst = 0;

      // T1: lane-0 AL packet replays after two advances
      drive(1, 3'd1, 16'h2034, 3'd0, 16'h1111, 0, 0, 0);
      tick();
      drive(1, 3'd0, 16'h0, 3'd0, 16'h0, 0, 0, 0);
      @(negedge clk);
      chk("t1_flush", bus.flush_out, 1);
      tick();
      @(negedge clk);
      chk("t1_p0_do", bus.p0_do_delayed_B, 1);
      chk("t1_replay_IR", bus.replay_IR, 16'h2034);
      chk("t1_flush_once", bus.flush_out, 0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.busy) n++;
         tick();
         @(negedge clk);
      end
      chk("t1_busy_len", n, 1 + DRAIN_CYCLES);

      // T2: p0 EQ false (Z=0), p1 LE true (N=1,V=0)
      tick();
      drive(1, 3'd2, 16'hA0B0, 3'd5, 16'hC0D5, 0, 0, 0);
      tick();
      drive(1, 3'd0, 16'h0, 3'd0, 16'h0, 1, 0, 0);
      tick();
      @(negedge clk);
      chk("t2_p1_do", bus.p1_do_delayed_B, 1);
      chk("t2_p0_do", bus.p0_do_delayed_B, 0);
      chk("t2_replay_IR", bus.replay_IR, 16'hC0D5);
      tick();
      drive(1, 3'd0, 16'h0, 3'd0, 16'h0, 0, 0, 0);
      repeat (4) tick();

      // T3: both lanes AL, only lane 0 replays
      drive(1, 3'd1, 16'h1234, 3'd1, 16'h5678, 0, 0, 0);
      tick();
      drive(1, 3'd0, 16'h0, 3'd0, 16'h0, 0, 0, 0);
      tick();
      // T4: stall in REPLAY; AL packets on input must be ignored
      drive(0, 3'd1, 16'hDEAD, 3'd1, 16'hDEAD, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_p0_hold", bus.p0_do_delayed_B, 1);
         chk("t4_p1_low", bus.p1_do_delayed_B, 0);
         chk("t4_ir_hold", bus.replay_IR, 16'h1234);
         tick();
         if (i == 2) bus.fetch_next_in = 1;
      end

      // T5: AL packets throughout DRAIN are never replayed
      n = 0;
      @(negedge clk);
      while (bus.busy && n < 10) begin
         tick();
         @(negedge clk);
         n++;
      end
      chk("t5_drain_len", n, DRAIN_CYCLES);
      #1 drive(1, 3'd1, 16'hBEEF, 3'd0, 16'h0, 0, 0, 0);
      tick();
      drive(1, 3'd0, 16'h0, 3'd0, 16'h0, 0, 0, 0);
      @(negedge clk);
      chk("t5_flush", bus.flush_out, 1);
      tick();
      @(negedge clk);
      chk("t5_p0_do", bus.p0_do_delayed_B, 1);
      chk("t5_replay_IR", bus.replay_IR, 16'hBEEF);

      // T6: reset in the middle of REPLAY
      #1 rst = 1;
      bus.fetch_next_in = 0;
      tick();
      @(negedge clk);
      chk("t6_p0_do", bus.p0_do_delayed_B, 0);
      chk("t6_busy", bus.busy, 0);
      chk("t6_replay_IR", bus.replay_IR, 16'h0000);
      #1 rst = 0;
      drive(1, 3'd0, 16'h0, 3'd1, 16'h4321, 0, 0, 0);
      tick();
      drive(1, 3'd0, 16'h0, 3'd0, 16'h0, 0, 0, 0);
      tick();
      @(negedge clk);
      chk("t6_p1_do", bus.p1_do_delayed_B, 1);
      chk("t6_replay_IR_p1", bus.replay_IR, 16'h4321);

      // Randomized traffic with stalls and occasional resets
      for (int i = 0; i < 3000; i++) begin
         tick();
         rst = ($urandom_range(0, 199) == 0);
         bus.fetch_next_in       = ($urandom_range(0, 4) != 0);
         bus.p0_delayed_cond_1in = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
         bus.p1_delayed_cond_1in = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
         bus.p0_delayed_B_1in    = 16'($urandom);
         bus.p1_delayed_B_1in    = 16'($urandom);
         bus.N = 1'($urandom); bus.V = 1'($urandom); bus.Z = 1'($urandom);
      end
      tick();
      @(negedge clk);
      #1 check_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
